// File: rtl/pmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pmem_pkg
//  Purpose  : Shared definitions for the program-memory download loader:
//             frame FSM state encoding, error-code values and the default
//             frame header byte.
//  Revision : 1.0  initial release
// ============================================================================
package pmem_pkg;

  // Frame parser states. Seven states fit in three bits.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AHI  = 3'd1,
    ST_ALO  = 3'd2,
    ST_CNT  = 3'd3,
    ST_DHI  = 3'd4,
    ST_DLO  = 3'd5,
    ST_CHK  = 3'd6
  } pmem_state_t;

  // err_code values.
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_CKSUM = 2'b01;
  localparam logic [1:0] ERR_FMT   = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  // Default frame header byte.
  localparam logic [7:0] C_SYNC_BYTE_DEFAULT = 8'hA5;

endpackage : pmem_pkg
`default_nettype wire

// File: rtl/pmem_frame_cksum.sv
`default_nettype none
// ============================================================================
//  Module   : pmem_frame_cksum
//  Purpose  : 8-bit running-sum accumulator for download frames.
//  Ports    : clk, reset   - clock and synchronous active-high reset
//             i_clr        - clear the sum (takes priority over i_add)
//             i_add        - add i_data into the sum this cycle
//             i_data       - byte presented this cycle
//             o_zero       - the sum including i_data is zero; lets the
//                            frame parser judge the checksum byte in the
//                            same cycle it is accepted
//  Revision : 1.0  initial release
// ============================================================================
module pmem_frame_cksum (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_add,
  input  logic [7:0] i_data,
  output logic       o_zero
);

  logic [7:0] r_sum;
  logic [7:0] w_sum_next;

  assign w_sum_next = r_sum + i_data;
  assign o_zero     = (w_sum_next == 8'h00);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum <= 8'h00;
    end else if (i_clr) begin
      r_sum <= 8'h00;
    end else if (i_add) begin
      r_sum <= w_sum_next;
    end
  end

endmodule : pmem_frame_cksum
`default_nettype wire

// File: rtl/prog_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_mem_loader
//  Purpose  : Converts framed download byte packets into word writes to the
//             writable program memory, holding the core in reset while a
//             frame is in progress.
//             Frame: SYNC, ADDR_HI, ADDR_LO, COUNT, COUNT x (DATA_HI,
//             DATA_LO), CK. The 8-bit sum of all bytes after SYNC,
//             including CK, must be zero.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             rx_data/valid/ready   - byte input handshake
//             mem_we/addr/wdata     - one-cycle program memory write
//             cpu_hold              - core held in reset during a frame
//             done                  - one-cycle pulse on a good frame
//             err, err_code         - sticky error flag and its cause
//  Options  : PMEM_LOADER_TIMEOUT_EN - when defined, a frame idle for
//             TIMEOUT_CYC clocks is aborted with err_code = timeout.
//  Revision : 1.0  initial release
// ============================================================================
module prog_mem_loader
  import pmem_pkg::*;
#(
  parameter int         ADDR_W      = 11,
  parameter int         DATA_W      = 14,
  parameter logic [7:0] SYNC_BYTE   = C_SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  // Number of meaningful bits carried by DATA_HI.
  localparam int DHI_BITS = DATA_W - 8;

  pmem_state_t       r_state;
  logic [2:0]        r_ahi;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_cnt;
  logic [7:0]        r_dhi;

  logic              w_acc;
  logic              w_dhi_bad;
  logic [15:0]       w_cat;
  logic [DATA_W-1:0] w_word;
  logic              w_ck_ok;
  logic              w_sum_clr;
  logic              w_sum_add;

  assign w_acc     = rx_valid & rx_ready;
  assign w_dhi_bad = ((rx_data >> DHI_BITS) != 8'h00);
  // DATA_HI upper bits are verified zero, so truncation assembles the word.
  assign w_cat     = {r_dhi, rx_data};
  assign w_word    = w_cat[DATA_W-1:0];

  assign w_sum_clr = w_acc && (r_state == ST_IDLE) && (rx_data == SYNC_BYTE);
  assign w_sum_add = w_acc && (r_state != ST_IDLE);

  pmem_frame_cksum u_cksum (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_sum_clr),
    .i_add  (w_sum_add),
    .i_data (rx_data),
    .o_zero (w_ck_ok)
  );

`ifdef PMEM_LOADER_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMO_W-1:0] r_tmo;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_ahi     <= 3'd0;
      r_addr    <= '0;
      r_cnt     <= 8'd0;
      r_dhi     <= 8'd0;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
`ifdef PMEM_LOADER_TIMEOUT_EN
      r_tmo     <= '0;
`endif
    end else begin
      rx_ready <= 1'b1;
      mem_we   <= 1'b0;
      done     <= 1'b0;

`ifdef PMEM_LOADER_TIMEOUT_EN
      // An accepted byte always beats the terminal count.
      if (w_acc || (r_state == ST_IDLE)) begin
        r_tmo <= '0;
      end else if (r_tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
        r_tmo    <= '0;
        r_state  <= ST_IDLE;
        cpu_hold <= 1'b0;
        err      <= 1'b1;
        err_code <= ERR_TMO;
      end else begin
        r_tmo <= r_tmo + 1'b1;
      end
`endif

      if (w_acc) begin
        case (r_state)
          ST_IDLE: begin
            // Anything other than the header byte is line noise.
            if (rx_data == SYNC_BYTE) begin
              r_state  <= ST_AHI;
              cpu_hold <= 1'b1;
              err      <= 1'b0;
              err_code <= ERR_NONE;
            end
          end
          ST_AHI: begin
            if (rx_data[7:3] != 5'd0) begin
              r_state  <= ST_IDLE;
              cpu_hold <= 1'b0;
              err      <= 1'b1;
              err_code <= ERR_FMT;
            end else begin
              r_ahi   <= rx_data[2:0];
              r_state <= ST_ALO;
            end
          end
          ST_ALO: begin
            r_addr  <= ADDR_W'({r_ahi, rx_data});
            r_state <= ST_CNT;
          end
          ST_CNT: begin
            if (rx_data == 8'd0) begin
              r_state  <= ST_IDLE;
              cpu_hold <= 1'b0;
              err      <= 1'b1;
              err_code <= ERR_FMT;
            end else begin
              r_cnt   <= rx_data;
              r_state <= ST_DHI;
            end
          end
          ST_DHI: begin
            if (w_dhi_bad) begin
              r_state  <= ST_IDLE;
              cpu_hold <= 1'b0;
              err      <= 1'b1;
              err_code <= ERR_FMT;
            end else begin
              r_dhi   <= rx_data;
              r_state <= ST_DLO;
            end
          end
          ST_DLO: begin
            mem_we    <= 1'b1;
            mem_addr  <= r_addr;
            mem_wdata <= w_word;
            r_addr    <= r_addr + 1'b1;
            r_cnt     <= r_cnt - 8'd1;
            r_state   <= (r_cnt == 8'd1) ? ST_CHK : ST_DHI;
          end
          ST_CHK: begin
            r_state  <= ST_IDLE;
            cpu_hold <= 1'b0;
            if (w_ck_ok) begin
              done <= 1'b1;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_CKSUM;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule : prog_mem_loader
`default_nettype wire

// File: tb/tb_prog_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_mem_loader
//  Purpose  : Self-checking bench for prog_mem_loader: table of download
//             frames with hand-computed writes and status, plus directed
//             sequences for hold timing, error clearing and mid-frame reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_mem_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [13:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  prog_mem_loader dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err),
    .err_code  (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observed writes {addr, data} and done pulses, sampled mid-cycle.
  logic [24:0] wq[$];
  int          ndone;

  always @(negedge clk) begin
    if (mem_we) wq.push_back({mem_addr, mem_wdata});
    if (done)   ndone = ndone + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic gap);
    if (gap) begin
      rx_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  typedef struct {
    logic [95:0] bytes;  // right-aligned, first byte most significant
    int          n;
    logic        alt;    // idle cycle before every byte
    int          nw;
    logic [10:0] a0;
    logic [13:0] d0;
    logic [10:0] a1;
    logic [13:0] d1;
    int          nd;
    logic        e;
    logic [1:0]  code;
  } vec_t;

  vec_t vt[7];

  task automatic clear_obs();
    wq.delete();
    ndone = 0;
  endtask

  task automatic check_frame(input vec_t v, input string tag);
    chk({tag, "_nwrites"}, wq.size(), v.nw);
    if (v.nw > 0 && wq.size() > 0) chk({tag, "_w0"}, wq[0], {v.a0, v.d0});
    if (v.nw > 1 && wq.size() > 1) chk({tag, "_w1"}, wq[1], {v.a1, v.d1});
    chk({tag, "_done"},     ndone,    v.nd);
    chk({tag, "_err"},      err,      v.e);
    chk({tag, "_err_code"}, err_code, v.code);
    chk({tag, "_cpu_hold"}, cpu_hold, 1'b0);
  endtask

  initial begin
    vt[0] = '{96'hA5000002300300A526, 9, 1'b0, 2, 11'h000, 14'h3003, 11'h001, 14'h00A5, 1, 1'b0, 2'b00};
    vt[1] = '{96'hA507FF02280E280496, 9, 1'b0, 2, 11'h7FF, 14'h280E, 11'h000, 14'h2804, 1, 1'b0, 2'b00};
    vt[2] = '{96'hA5000002300300A527, 9, 1'b0, 2, 11'h000, 14'h3003, 11'h001, 14'h00A5, 0, 1'b1, 2'b01};
    vt[3] = '{96'hA5000000,           4, 1'b0, 0, 11'h000, 14'h0000, 11'h000, 14'h0000, 0, 1'b1, 2'b10};
    vt[4] = '{96'hA500000140,         5, 1'b0, 0, 11'h000, 14'h0000, 11'h000, 14'h0000, 0, 1'b1, 2'b10};
    vt[5] = '{96'h1234A5000002300300A526, 11, 1'b1, 2, 11'h000, 14'h3003, 11'h001, 14'h00A5, 1, 1'b0, 2'b00};
    vt[6] = '{96'hA508,               2, 1'b0, 0, 11'h000, 14'h0000, 11'h000, 14'h0000, 0, 1'b1, 2'b10};

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    ndone    = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready",  rx_ready,  1'b0);
    chk("rst_mem_we",    mem_we,    1'b0);
    chk("rst_mem_addr",  mem_addr,  11'h000);
    chk("rst_mem_wdata", mem_wdata, 14'h0000);
    chk("rst_cpu_hold",  cpu_hold,  1'b0);
    chk("rst_done",      done,      1'b0);
    chk("rst_err",       err,       1'b0);
    chk("rst_err_code",  err_code,  2'b00);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("run_rx_ready", rx_ready, 1'b1);

    for (int k = 0; k < 7; k++) begin
      clear_obs();
      for (int i = 0; i < vt[k].n; i++)
        send(vt[k].bytes[8*(vt[k].n-1-i) +: 8], vt[k].alt);
      repeat (3) @(posedge clk);
      #1;
      check_frame(vt[k], $sformatf("vec%0d", k));
    end

    // Hold timing, error clearing on a new header, then reset mid-frame.
    clear_obs();
    send(8'h12, 1'b0);
    chk("seq_noise_hold", cpu_hold, 1'b0);
    send(8'hA5, 1'b0);
    chk("seq_sync_hold",   cpu_hold, 1'b1);
    chk("seq_sync_err",    err,      1'b0);
    chk("seq_sync_code",   err_code, 2'b00);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h02, 1'b0);
    send(8'h30, 1'b0);
    chk("seq_mid_hold", cpu_hold, 1'b1);
    chk("seq_mid_we",   wq.size(), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_rx_ready",  rx_ready,  1'b0);
    chk("mrst_mem_we",    mem_we,    1'b0);
    chk("mrst_mem_addr",  mem_addr,  11'h000);
    chk("mrst_mem_wdata", mem_wdata, 14'h0000);
    chk("mrst_cpu_hold",  cpu_hold,  1'b0);
    chk("mrst_done",      done,      1'b0);
    chk("mrst_err",       err,       1'b0);
    chk("mrst_err_code",  err_code,  2'b00);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_rx_ready_after", rx_ready, 1'b1);

    // A full frame after the abandoned one proves the parser restarted idle.
    clear_obs();
    for (int i = 0; i < vt[0].n; i++)
      send(vt[0].bytes[8*(vt[0].n-1-i) +: 8], 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_frame(vt[0], "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_prog_mem_loader
`default_nettype wire
